// File: rtl/card_shoe.sv
// card_shoe: 52-card shoe with an LFSR-driven Fisher-Yates shuffle (one swap
// per cycle) and a draw pointer that pops one card per cycle.

package poker_types;
    typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
    typedef enum logic [3:0] {TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT,
                              NINE, TEN, JACK, QUEEN, KING, ACE} rank_t;
    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;
endpackage

module card_shoe
    import poker_types::*;
#(
    parameter logic [15:0] SEED = 16'hACE1   // must be nonzero
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_shuffle,
    input  logic       draw_card,
    output card_t      top_card,
    output logic       ready,
    output logic       empty,
    output logic [5:0] cards_remaining
);

    typedef enum logic [1:0] {IDLE, SHUFFLE, READY} state_t;

    localparam logic [5:0] DECK = 6'd52;

    state_t      state, state_nx;
    card_t       slot [52];
    logic [5:0]  idx;
    logic [5:0]  ptr;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nx;
    logic [5:0]  idx_p1;
    logic [5:0]  j;
    logic        load, shuf, pop;

    // Canonical card for deck index k: suit k/13, rank k%13.
    function automatic card_t canon(input logic [5:0] k);
        return card_t'({2'(k / 6'd13), 4'(k % 6'd13)});
    endfunction

    // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form).
    assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Scaled pick j = floor(lfsr*(idx+1)/2^16) always lands in 0..idx.
    assign idx_p1 = idx + 6'd1;
    assign j      = 6'((22'(lfsr) * 22'(idx_p1)) >> 16);

    // A start request wins over a draw; a shuffle in flight ignores starts.
    assign load = (state != SHUFFLE) && start_shuffle;
    assign shuf = (state == SHUFFLE);
    assign pop  = (state == READY) && !start_shuffle && draw_card && (ptr != DECK);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and the ready flag.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE:    if (start_shuffle) state_nx = SHUFFLE;
            SHUFFLE: if (idx == 6'd1)   state_nx = READY;
            READY: begin
                ready = 1'b1;
                if (start_shuffle) state_nx = SHUFFLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: free-running LFSR, deck slots, shuffle index and draw pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
            idx  <= '0;
            ptr  <= '0;
            for (int k = 0; k < 52; k++) slot[k] <= canon(6'(k));
        end else begin
            lfsr <= lfsr_nx;
            if (load) begin
                idx <= 6'd51;
                ptr <= '0;
                for (int k = 0; k < 52; k++) slot[k] <= canon(6'(k));
            end else if (shuf) begin
                // j == idx degenerates to both branches writing the same value
                for (int k = 0; k < 52; k++) begin
                    if (6'(k) == idx)    slot[k] <= slot[j];
                    else if (6'(k) == j) slot[k] <= slot[idx];
                end
                idx <= idx - 6'd1;
            end else if (pop) begin
                ptr <= ptr + 6'd1;
            end
        end
    end

    // Output view of the deck; outside READY the shoe looks empty.
    always_comb begin
        top_card        = canon(6'd0);
        cards_remaining = 6'd0;
        if (state == READY) begin
            cards_remaining = DECK - ptr;
            if (ptr < DECK) top_card = slot[ptr];
        end
        empty = (cards_remaining == 6'd0);
    end

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: table vectors, directed corner sequences and random draws
// against a Fisher-Yates / LFSR reference model.

module tb_card_shoe;
    import poker_types::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_shuffle;
    logic       draw_card;
    card_t      top_card;
    logic       ready;
    logic       empty;
    logic [5:0] cards_remaining;
    logic [5:0] tc;

    int n_chk  = 0;
    int n_fail = 0;
    int ecnt   = 0;        // index of the next non-reset edge since reset
    int exp_deck [52];     // model deck as canonical indices
    int seen     [53];     // card indices observed by the last full draw
    int order1   [52];

    card_shoe #(.SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start_shuffle(start_shuffle),
        .draw_card(draw_card), .top_card(top_card), .ready(ready),
        .empty(empty), .cards_remaining(cards_remaining)
    );

    assign tc = top_card;

    always #5 clk = ~clk;

    typedef struct {
        bit draw;
        bit exp_ready;
        int exp_rem;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int card_code(input int k);
        return (k / 13) * 16 + (k % 13);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] x = 16'hACE1;
        for (int i = 0; i < n; i++) x = lfsr_step(x);
        return x;
    endfunction

    // Fisher-Yates from canonical order; the swap for position i happens on
    // edge s+52-i, using the LFSR value present at that edge.
    task automatic model_shuffle(input int s);
        logic [15:0] x;
        int jj, t;
        x = lfsr_at(s + 1);
        for (int k = 0; k < 52; k++) exp_deck[k] = k;
        for (int i = 51; i >= 1; i--) begin
            jj = (int'(x) * (i + 1)) / 65536;
            t = exp_deck[i]; exp_deck[i] = exp_deck[jj]; exp_deck[jj] = t;
            x = lfsr_step(x);
        end
    endtask

    task automatic tick();
        if (reset) ecnt = 0;
        else       ecnt++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; start_shuffle = 1'b0; draw_card = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    // Pulse start (optionally with draw), check latency and build the model.
    task automatic run_shuffle(input string tag, input bit with_draw);
        int s, lat;
        start_shuffle = 1'b1; draw_card = with_draw; s = ecnt;
        tick();
        start_shuffle = 1'b0; draw_card = 1'b0;
        chk({tag, "_ready_after_start"}, ready, 0);
        chk({tag, "_rem_after_start"}, cards_remaining, 0);
        // latency counts the sampling edge as edge 1
        lat = 1;
        while (!ready && lat < 200) begin tick(); lat++; end
        chk({tag, "_latency"}, lat, 52);
        chk({tag, "_rem_full"}, cards_remaining, 52);
        chk({tag, "_empty_full"}, empty, 0);
        model_shuffle(s);
    endtask

    // Hold draw for 53 cycles; check order, count, distinctness, overdraw.
    task automatic draw_all(input string tag);
        int distinct;
        bit hit [64];
        for (int i = 0; i < 64; i++) hit[i] = 1'b0;
        for (int i = 0; i <= 52; i++) begin
            seen[i] = int'(tc);
            chk({tag, "_top"}, int'(tc), (i < 52) ? card_code(exp_deck[i]) : 0);
            chk({tag, "_rem"}, cards_remaining, 52 - i);
            chk({tag, "_empty"}, empty, (i == 52) ? 1 : 0);
            if (i < 52) hit[tc] = 1'b1;
            draw_card = 1'b1;
            tick();
        end
        draw_card = 1'b0;
        distinct = 0;
        for (int i = 0; i < 64; i++) distinct += int'(hit[i]);
        chk({tag, "_distinct"}, distinct, 52);
        chk({tag, "_rem_after_overdraw"}, cards_remaining, 0);
        chk({tag, "_ready_after_overdraw"}, ready, 1);
        chk({tag, "_top_after_overdraw"}, int'(tc), 0);
    endtask

    initial begin
        vec_t vecs [13];
        int diff, ptr_m;

        reset = 1'b1; start_shuffle = 1'b0; draw_card = 1'b1;
        tick(); tick(); tick();
        chk("rst_ready", ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_rem", cards_remaining, 0);
        chk("rst_top", int'(tc), 0);

        // 100 idle cycles with draw held: nothing may happen
        reset = 1'b0; draw_card = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_state", {ready, empty, 6'(cards_remaining), 6'(tc)},
                {1'b0, 1'b1, 6'd0, 6'd0});
        end

        // start sampled on edge 10 after reset
        do_reset(2);
        for (int i = 0; i < 10; i++) tick();
        run_shuffle("s10", 1'b0);
        draw_all("s10");
        for (int i = 0; i < 52; i++) order1[i] = seen[i];

        // start sampled on edge 11: still model-exact, different order
        do_reset(2);
        for (int i = 0; i < 11; i++) tick();
        run_shuffle("s11", 1'b0);
        draw_all("s11");
        diff = 0;
        for (int i = 0; i < 52; i++) if (seen[i] != order1[i]) diff++;
        chk("s11_order_differs", int'(diff > 0), 1);

        // reset 20 cycles into a shuffle aborts it
        do_reset(2);
        start_shuffle = 1'b1; tick(); start_shuffle = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("abort_pre_ready", ready, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("abort_idle", {ready, 6'(cards_remaining), 6'(tc)}, 0);
        end
        run_shuffle("abort_restart", 1'b0);
        draw_all("abort_restart");

        // table: 10 draws, an idle, a start-less idle, then start+draw together
        for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b1, 51 - i};
        vecs[10] = '{1'b0, 1'b1, 42};
        vecs[11] = '{1'b0, 1'b1, 42};
        vecs[12] = '{1'b1, 1'b1, 41};
        run_shuffle("tbl", 1'b0);
        for (int i = 0; i < 13; i++) begin
            chk("tbl_top", int'(tc), card_code(exp_deck[52 - ((i == 0) ? 52 : vecs[i-1].exp_rem)]));
            draw_card = vecs[i].draw;
            tick();
            chk("tbl_ready", ready, int'(vecs[i].exp_ready));
            chk("tbl_rem", cards_remaining, vecs[i].exp_rem);
        end
        run_shuffle("tbl_restart", 1'b1);
        draw_all("tbl_restart");

        // random draw pattern against a pointer model
        run_shuffle("rnd", 1'b0);
        ptr_m = 0;
        for (int i = 0; i < 140; i++) begin
            draw_card = ($urandom_range(0, 99) < 55);
            tick();
            if (draw_card && ptr_m < 52) ptr_m++;
            chk("rnd_rem", cards_remaining, 52 - ptr_m);
            chk("rnd_top", int'(tc), (ptr_m < 52) ? card_code(exp_deck[ptr_m]) : 0);
            chk("rnd_empty", empty, int'(ptr_m == 52));
        end
        draw_card = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
